// File: rtl/mouse_pkg.sv
// Shared codes, FSM state encodings and the saturating accumulate helper
// for the device-side PS/2 mouse responder.
package mouse_pkg;

  localparam logic [7:0] CMD_RESET        = 8'hFF;
  localparam logic [7:0] CMD_RESEND       = 8'hFE;
  localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;
  localparam logic [7:0] CMD_DISABLE      = 8'hF5;
  localparam logic [7:0] CMD_ENABLE       = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE     = 8'hF3;
  localparam logic [7:0] CMD_GET_ID       = 8'hF2;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_ERROR  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_DEV_ID = 8'h00;

  localparam logic [3:0] ST_BAT_WAIT  = 4'd0;
  localparam logic [3:0] ST_SEND_BAT  = 4'd1;
  localparam logic [3:0] ST_SEND_ID   = 4'd2;
  localparam logic [3:0] ST_IDLE      = 4'd3;
  localparam logic [3:0] ST_SEND_ACK  = 4'd4;
  localparam logic [3:0] ST_SEND_RESP = 4'd5;
  localparam logic [3:0] ST_PKT_GAP   = 4'd6;
  localparam logic [3:0] ST_SEND_PKT0 = 4'd7;
  localparam logic [3:0] ST_SEND_PKT1 = 4'd8;
  localparam logic [3:0] ST_SEND_PKT2 = 4'd9;
  localparam logic [3:0] ST_RATE_WAIT = 4'd10;

  // What follows once an FA acknowledge has left the transmitter.
  typedef enum logic [1:0] {POST_IDLE, POST_BAT, POST_ID, POST_RATE} post_e;

  localparam int PKT_YOVF  = 7;
  localparam int PKT_XOVF  = 6;
  localparam int PKT_YSIGN = 5;
  localparam int PKT_XSIGN = 4;
  localparam int PKT_ONE   = 3;

  typedef struct packed {
    logic [9:0] val;
    logic       ovf;
  } sat_t;

  function automatic sat_t sat_add(input logic [9:0] acc, input logic [8:0] d);
    logic signed [10:0] s;
    sat_t r;
    s = $signed({acc[9], acc}) + $signed({{2{d[8]}}, d});
    r.ovf = 1'b1;
    if (s > 11'sd255)       r.val = 10'h0FF;
    else if (s < -11'sd256) r.val = 10'h300;
    else begin
      r.val = s[9:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mouse_move_accum.sv
// X/Y movement accumulators clamped to -256..+255 with sticky overflow,
// plus button-change detection against the last reported button state.
module mouse_move_accum
  import mouse_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       move_valid_i,
  input  logic [8:0] dx_i,
  input  logic [8:0] dy_i,
  input  logic [2:0] buttons_i,
  input  logic       latch_i,
  input  logic       clear_i,
  output logic [7:0] x_lo_o,
  output logic [7:0] y_lo_o,
  output logic       x_sign_o,
  output logic       y_sign_o,
  output logic       ovf_x_o,
  output logic       ovf_y_o,
  output logic       nonzero_o,
  output logic       btn_changed_o
);

  logic [9:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, base_x, base_y;
  logic       ovf_x_q, ovf_x_d, ovf_y_q, ovf_y_d, restart;
  logic [2:0] btn_last_q, btn_last_d;
  sat_t       sx, sy;

  // A move arriving on a latch/clear cycle starts the fresh sum.
  always_comb begin
    restart    = latch_i | clear_i;
    base_x     = restart ? 10'd0 : acc_x_q;
    base_y     = restart ? 10'd0 : acc_y_q;
    sx         = sat_add(base_x, dx_i);
    sy         = sat_add(base_y, dy_i);
    acc_x_d    = move_valid_i ? sx.val : base_x;
    acc_y_d    = move_valid_i ? sy.val : base_y;
    ovf_x_d    = (restart ? 1'b0 : ovf_x_q) | (move_valid_i & sx.ovf);
    ovf_y_d    = (restart ? 1'b0 : ovf_y_q) | (move_valid_i & sy.ovf);
    btn_last_d = latch_i ? buttons_i : btn_last_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      ovf_x_q    <= 1'b0;
      ovf_y_q    <= 1'b0;
      btn_last_q <= '0;
    end else begin
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      ovf_x_q    <= ovf_x_d;
      ovf_y_q    <= ovf_y_d;
      btn_last_q <= btn_last_d;
    end
  end

  assign x_lo_o        = acc_x_q[7:0];
  assign y_lo_o        = acc_y_q[7:0];
  assign x_sign_o      = acc_x_q[9];
  assign y_sign_o      = acc_y_q[9];
  assign ovf_x_o       = ovf_x_q;
  assign ovf_y_o       = ovf_y_q;
  assign nonzero_o     = (|acc_x_q) | (|acc_y_q);
  assign btn_changed_o = (buttons_i != btn_last_q);

endmodule

// File: rtl/mouse_device_sm.sv
// Device-side PS/2 mouse responder: boot BAT/ID, host command decode, 3-byte stream packets.
// Define MOUSE_DEV_ID_CMD_EN to answer F2 (Get Device ID) and F3 (Set Sample Rate).
module mouse_device_sm
  import mouse_pkg::*;
#(
  parameter int unsigned BAT_DELAY = 50_000,
  parameter int unsigned PKT_GAP   = 1_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  input  logic       MOVE_VALID,
  input  logic [8:0] MOVE_DX,
  input  logic [8:0] MOVE_DY,
  input  logic [2:0] MOVE_BUTTONS,
  output logic       REPORTING,
  output logic [3:0] current_state
);

  logic [3:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        send_q, busy_q, busy_d, rep_q, rep_d;
  logic [7:0]  byte_q, byte_d, pkt1_q, pkt1_d, pkt2_q, pkt2_d;
  logic        pend_q, pend_d, err_q, err_d;
  logic [7:0]  cmd_q, cmd_d;
  post_e       post_q, post_d;
`ifdef MOUSE_DEV_ID_CMD_EN
  logic [7:0]  rate_q, rate_d;
`endif

  logic       sent, boot_ff, do_cmd, tx_go, acc_latch, acc_clear;
  logic [7:0] tx_val, pkt0;
  logic [7:0] x_lo, y_lo;
  logic       x_sign, y_sign, ovf_x, ovf_y, acc_nz, btn_chg;

  mouse_move_accum u_accum (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .move_valid_i  (MOVE_VALID),
    .dx_i          (MOVE_DX),
    .dy_i          (MOVE_DY),
    .buttons_i     (MOVE_BUTTONS),
    .latch_i       (acc_latch),
    .clear_i       (acc_clear),
    .x_lo_o        (x_lo),
    .y_lo_o        (y_lo),
    .x_sign_o      (x_sign),
    .y_sign_o      (y_sign),
    .ovf_x_o       (ovf_x),
    .ovf_y_o       (ovf_y),
    .nonzero_o     (acc_nz),
    .btn_changed_o (btn_chg)
  );

  assign sent    = BYTE_SENT & busy_q;
  assign boot_ff = pend_q & ~err_q & (cmd_q == CMD_RESET);

  always_comb begin
    pkt0            = '0;
    pkt0[PKT_YOVF]  = ovf_y;
    pkt0[PKT_XOVF]  = ovf_x;
    pkt0[PKT_YSIGN] = y_sign;
    pkt0[PKT_XSIGN] = x_sign;
    pkt0[PKT_ONE]   = 1'b1;
    pkt0[2:0]       = MOVE_BUTTONS;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    byte_d    = byte_q;
    rep_d     = rep_q;
    pend_d    = pend_q;
    cmd_d     = cmd_q;
    err_d     = err_q;
    post_d    = post_q;
    pkt1_d    = pkt1_q;
    pkt2_d    = pkt2_q;
    acc_latch = 1'b0;
    acc_clear = 1'b0;
    do_cmd    = 1'b0;
    tx_go     = 1'b0;
    tx_val    = byte_q;
`ifdef MOUSE_DEV_ID_CMD_EN
    rate_d    = rate_q;
`endif
    if (sent) busy_d = 1'b0;

    case (state_q)
      ST_BAT_WAIT: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (boot_ff) begin
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_BAT; state_d = ST_SEND_ACK;
          end
        end else if (cnt_q == 32'd0) begin
          tx_go = 1'b1; tx_val = RSP_BAT_OK; state_d = ST_SEND_BAT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_SEND_BAT, ST_SEND_ID: begin
        if (sent) begin
          pend_d = 1'b0;
          if (boot_ff) begin
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_BAT; state_d = ST_SEND_ACK;
          end else if (state_q == ST_SEND_BAT) begin
            tx_go = 1'b1; tx_val = RSP_DEV_ID; state_d = ST_SEND_ID;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (pend_q) begin
          do_cmd = 1'b1;
        end else if (rep_q && (acc_nz || btn_chg)) begin
          acc_latch = 1'b1;
          tx_go     = 1'b1;
          tx_val    = pkt0;
          pkt1_d    = x_lo;
          pkt2_d    = y_lo;
          state_d   = ST_SEND_PKT0;
        end
      end
      ST_SEND_ACK: begin
        if (sent) begin
          case (post_q)
            POST_BAT:  begin cnt_d = 32'(BAT_DELAY - 1); state_d = ST_BAT_WAIT; end
            POST_ID:   begin tx_go = 1'b1; tx_val = RSP_DEV_ID; state_d = ST_SEND_RESP; end
            POST_RATE: state_d = ST_RATE_WAIT;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_SEND_RESP: if (sent) state_d = ST_IDLE;
      ST_PKT_GAP: begin
        if (pend_q)                do_cmd = 1'b1;
        else if (cnt_q == 32'd0)   state_d = ST_IDLE;
        else                       cnt_d = cnt_q - 32'd1;
      end
      // A command received mid-packet aborts the packet once the current byte is out.
      ST_SEND_PKT0: if (sent) begin
        if (pend_q) do_cmd = 1'b1;
        else begin tx_go = 1'b1; tx_val = pkt1_q; state_d = ST_SEND_PKT1; end
      end
      ST_SEND_PKT1: if (sent) begin
        if (pend_q) do_cmd = 1'b1;
        else begin tx_go = 1'b1; tx_val = pkt2_q; state_d = ST_SEND_PKT2; end
      end
      ST_SEND_PKT2: if (sent) begin
        if (pend_q) do_cmd = 1'b1;
        else begin cnt_d = 32'(PKT_GAP - 1); state_d = ST_PKT_GAP; end
      end
`ifdef MOUSE_DEV_ID_CMD_EN
      ST_RATE_WAIT: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (err_q) begin
            tx_go = 1'b1; tx_val = RSP_ERROR; state_d = ST_SEND_RESP;
          end else begin
            rate_d = cmd_q;
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_IDLE; state_d = ST_SEND_ACK;
          end
        end
      end
`endif
      default: begin
        cnt_d   = 32'(BAT_DELAY - 1);
        state_d = ST_BAT_WAIT;
      end
    endcase

    if (do_cmd) begin
      pend_d = 1'b0;
      if (err_q) begin
        tx_go = 1'b1; tx_val = RSP_ERROR; state_d = ST_SEND_RESP;
      end else begin
        case (cmd_q)
          CMD_RESET: begin
            rep_d = 1'b0;
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_BAT; state_d = ST_SEND_ACK;
          end
          CMD_ENABLE: begin
            rep_d = 1'b1;
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_IDLE; state_d = ST_SEND_ACK;
          end
          CMD_DISABLE: begin
            rep_d = 1'b0; acc_clear = 1'b1;
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_IDLE; state_d = ST_SEND_ACK;
          end
          CMD_SET_DEFAULTS: begin
            rep_d = 1'b0;
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_IDLE; state_d = ST_SEND_ACK;
          end
          CMD_RESEND: begin
            tx_go = 1'b1; tx_val = byte_q; state_d = ST_SEND_RESP;
          end
`ifdef MOUSE_DEV_ID_CMD_EN
          CMD_GET_ID: begin
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_ID; state_d = ST_SEND_ACK;
          end
          CMD_SET_RATE: begin
            tx_go = 1'b1; tx_val = RSP_ACK; post_d = POST_RATE; state_d = ST_SEND_ACK;
          end
`endif
          default: begin
            tx_go = 1'b1; tx_val = RSP_ERROR; state_d = ST_SEND_RESP;
          end
        endcase
      end
    end

    if (tx_go) begin
      busy_d = 1'b1;
      byte_d = tx_val;
    end

    if (BYTE_READY) begin
      pend_d = 1'b1;
      cmd_d  = BYTE_READ;
      err_d  = |BYTE_ERROR_CODE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_BAT_WAIT;
      cnt_q   <= 32'(BAT_DELAY - 1);
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      byte_q  <= 8'h00;
      rep_q   <= 1'b0;
      pend_q  <= 1'b0;
      cmd_q   <= 8'h00;
      err_q   <= 1'b0;
      post_q  <= POST_IDLE;
      pkt1_q  <= 8'h00;
      pkt2_q  <= 8'h00;
`ifdef MOUSE_DEV_ID_CMD_EN
      rate_q  <= 8'd100;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      send_q  <= tx_go;
      busy_q  <= busy_d;
      byte_q  <= byte_d;
      rep_q   <= rep_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      post_q  <= post_d;
      pkt1_q  <= pkt1_d;
      pkt2_q  <= pkt2_d;
`ifdef MOUSE_DEV_ID_CMD_EN
      rate_q  <= rate_d;
`endif
    end
  end

  assign SEND_BYTE     = send_q;
  assign BYTE_TO_SEND  = byte_q;
  assign READ_ENABLE   = (state_q != ST_BAT_WAIT) && !busy_q;
  assign REPORTING     = rep_q;
  assign current_state = state_q;

endmodule
